// File: rtl/tri_bbox_if.sv
// Handshake and data bundle between the setup stage, the bounding-box unit and the scan stage.
interface tri_bbox_if #(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 6,
  parameter int COUNT_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        v0x, v1x, v2x, v0y, v1y, v2y;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-FRAC-1:0]   xmin, xmax, ymin, ymax;
  logic                    cull;
  logic [COUNT_W-1:0]      tri_count;

  modport master (
    output in_valid, v0x, v1x, v2x, v0y, v1y, v2y, out_ready,
    input  in_ready, out_valid, xmin, xmax, ymin, ymax, cull, tri_count
  );

  modport slave (
    input  in_valid, v0x, v1x, v2x, v0y, v1y, v2y, out_ready,
    output in_ready, out_valid, xmin, xmax, ymin, ymax, cull, tri_count
  );
endinterface

// File: rtl/tri_bbox_unit.sv
// Triangle bounding box: min/max of three fixed-point vertices, rounded to pixels,
// saturated, clamped to the screen and flagged for culling when fully off-screen.
module tri_bbox_unit #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 6,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int COUNT_W  = 8
) (
  input  logic     clk,
  input  logic     rst,
  tri_bbox_if.slave bus
);
  localparam int PW = WIDTH - FRAC;
  localparam int unsigned XLIM = SCREEN_W - 1;
  localparam int unsigned YLIM = SCREEN_H - 1;

  typedef enum logic [1:0] {IDLE, MINMAX, ROUND, HOLD} state_t;
  state_t state;

  logic [WIDTH-1:0]   x0, x1, x2, y0, y1, y2;
  logic [WIDTH-1:0]   xlo, xhi, ylo, yhi;
  logic [PW-1:0]      rxlo, rxhi, rylo, ryhi;
  logic [PW-1:0]      xmin_q, xmax_q, ymin_q, ymax_q;
  logic               rdy_q, val_q, cull_q;
  logic [COUNT_W-1:0] cnt_q;

  function automatic logic [WIDTH-1:0] min3(input logic [WIDTH-1:0] a, b, c);
    logic [WIDTH-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [WIDTH-1:0] max3(input logic [WIDTH-1:0] a, b, c);
    logic [WIDTH-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Round half-up; the extra carry bit detects overflow past the pixel range.
  function automatic logic [PW-1:0] round_sat(input logic [WIDTH-1:0] v);
    logic [PW:0] r;
    r = {1'b0, v[WIDTH-1:FRAC]} + {{PW{1'b0}}, v[FRAC-1]};
    return r[PW] ? '1 : r[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] clamp(input logic [PW-1:0] r, input int unsigned lim);
    return (32'(r) > lim) ? PW'(lim) : r;
  endfunction

  assign rxlo = round_sat(xlo);
  assign rxhi = round_sat(xhi);
  assign rylo = round_sat(ylo);
  assign ryhi = round_sat(yhi);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rdy_q  <= 1'b1;
      val_q  <= 1'b0;
      cull_q <= 1'b0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
      cnt_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x0    <= bus.v0x;
            x1    <= bus.v1x;
            x2    <= bus.v2x;
            y0    <= bus.v0y;
            y1    <= bus.v1y;
            y2    <= bus.v2y;
            rdy_q <= 1'b0;
            state <= MINMAX;
          end
        end
        MINMAX: begin
          xlo   <= min3(x0, x1, x2);
          xhi   <= max3(x0, x1, x2);
          ylo   <= min3(y0, y1, y2);
          yhi   <= max3(y0, y1, y2);
          state <= ROUND;
        end
        ROUND: begin
          xmin_q <= clamp(rxlo, XLIM);
          xmax_q <= clamp(rxhi, XLIM);
          ymin_q <= clamp(rylo, YLIM);
          ymax_q <= clamp(ryhi, YLIM);
          cull_q <= (32'(rxlo) > XLIM) | (32'(rylo) > YLIM);
          val_q  <= 1'b1;
          state  <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            val_q <= 1'b0;
            rdy_q <= 1'b1;
            cnt_q <= cnt_q + COUNT_W'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ready is masked by reset so upstream never sees it while reset is held.
  assign bus.in_ready  = rdy_q & ~rst;
  assign bus.out_valid = val_q;
  assign bus.xmin      = xmin_q;
  assign bus.xmax      = xmax_q;
  assign bus.ymin      = ymin_q;
  assign bus.ymax      = ymax_q;
  assign bus.cull      = cull_q;
  assign bus.tri_count = cnt_q;
endmodule
